macc_array: RTL
===============

# macc_array

Parametrised multi-lane fixed-point multiply-accumulate engine, successor to the single-lane MACC primitive in the PE datapath. It applies one op code per beat across LANES lanes and holds per-lane accumulators across multi-beat runs. It emits rounded, optionally saturated results under a valid/ready handshake. It sits between the operand buffers and the PE output/normalisation stage.

## Interface
- LANES, 4, number of parallel lanes
- DATA_WIDTH, 16, operand and op_add width (signed, Q(INT).FRAC)
- FRAC_BITS, 15, fractional bits of operands and result
- OUT_WIDTH, 16, result width per lane
- ACC_GUARD, 8, accumulator overflow guard bits; ACC_WIDTH = 2*DATA_WIDTH + ACC_GUARD
- clk  in  1  clock
- reset  in  1  reset; one clock, reset is synchronous and active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of an accumulate run
- op_code  in  3  bit0 square, bit1 accumulate, bit2 add op_add
- op_0  in  LANES*DATA_WIDTH  packed signed multiplicands, lane 0 at LSBs
- op_1  in  LANES*DATA_WIDTH  packed signed multipliers (ignored when op_code[0])
- op_add  in  LANES*DATA_WIDTH  packed signed addends
- clear  in  1  discard accumulators and any open run
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  LANES*OUT_WIDTH  packed signed results
- out_sat  out  LANES  per-lane saturation flag

## Operation
- Product p = op_0 * (op_code[0] ? op_0 : op_1), full 2*DATA_WIDTH signed.
- Addend: op_code[1] → running accumulator; else op_code[2] → sign-extended op_add <<< FRAC_BITS; else 0. Codes 6/7 behave as 2/3.
- acc_next = p + addend in ACC_WIDTH. Accumulator overflow wraps silently.
- Emit rule: non-accumulate beat emits every beat. Accumulate beat emits only with in_last, then zeroes the accumulator. Accumulate beat without last produces no output.
- Output: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, round half up, then narrowed to OUT_WIDTH per Configuration.
- clear: sampled every cycle regardless of in_valid and travels with the pipeline. It zeroes the accumulators before any beat accepted in the same cycle is combined. A run open at clear is dropped with no output.
- Reset: all pipeline valids 0, accumulators 0, out_valid 0, out_data 0, out_sat 0, in_ready 0 while reset is high.

## Timing
- Four stages: S1 operand register, S2 multiply, S3 add/accumulate, S4 round/narrow into the output register.
- Latency: 4 cycles from acceptance to out_valid with no stall. Throughput: one beat per cycle.
- Global advance: adv = out_ready || !out_valid. in_ready = adv && !reset, combinational.
- When adv is 0, all stages, accumulators and the clear pipeline hold. out_data and out_sat stay stable while out_valid && !out_ready.
- Bubbles (in_valid=0) propagate as invalid slots. They never modify the accumulators.
- Simultaneous clear with in_last: the run becomes that single beat's product, which is emitted.

## Configuration
- MACC_ARRAY_SAT_EN defined: r outside the OUT_WIDTH signed range clamps to max/min, and the lane's out_sat is 1 for that result.
- Not defined: r keeps its low OUT_WIDTH bits (wrap), and out_sat is tied 0.

## Structure
- Package macc_pkg: op-code bit positions and named codes (MUL=0, SQR=1, MAC=2, SQRACC=3, MADD=4, SQRADD=5), default ACC_GUARD, and the ACC_WIDTH function.
- Sub-module macc_lane: one lane's S1–S4 datapath, its accumulator and its rounding/saturation. It takes adv, stage valids and clear from the parent.
- macc_array instantiates LANES copies and owns the handshake, the valid/last/op_code pipeline and the emit logic.

## Test plan
- MUL, all lanes op_0=op_1=0x4000 (0.5) → after 4 cycles out_data lanes = 0x2000, out_sat=0.
- SQR, op_0=0xC000, op_1=0x7FFF → 0x2000; MADD, 0x4000*0x4000 + op_add 0x1000 → 0x3000.
- MAC, four beats of 0x4000*0x4000, in_last on the 4th → one output: with macro 0x7FFF and out_sat=1; without macro 0x8000 and out_sat=0.
- Rounding: MUL, 0x0001*0x4000 → 0x0001; 0xFFFF*0x4000 → 0x0000.
- Backpressure: stream 8 MUL beats with out_ready low for cycles 5–9 → no beat lost or duplicated, output held stable, in_ready low while stalled, results in order.
- clear asserted after 2 of 4 MAC beats, then 2 more beats with last (0x4000*0x4000 each) → single output 0x4000. Reset mid-run → all outputs 0 and the next run starts from a zero accumulator.

Source files
------------

// File: rtl/macc_pkg.sv
// macc_pkg: op-code bit positions, named op codes and accumulator sizing
// shared by macc_array and macc_lane.
package macc_pkg;

    // op_code bit meanings
    localparam int OP_SQR_BIT = 0;   // multiply op_0 by itself
    localparam int OP_ACC_BIT = 1;   // add the running accumulator
    localparam int OP_ADD_BIT = 2;   // add op_add (ignored when OP_ACC_BIT set)

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        SQR    = 3'd1,
        MAC    = 3'd2,
        SQRACC = 3'd3,
        MADD   = 3'd4,
        SQRADD = 3'd5
    } op_e;

    localparam int DEFAULT_ACC_GUARD = 8;

    // Full-precision product plus guard bits against run overflow
    function automatic int acc_width(input int data_width, input int guard);
        return 2 * data_width + guard;
    endfunction

endpackage

// File: rtl/macc_lane.sv
// macc_lane: one lane of macc_array. S1 operand register, S2 multiply,
// S3 add/accumulate (owns the lane accumulator), S4 round/narrow into the
// output register. Stage valids, clear and advance come from the parent.
// MACC_ARRAY_SAT_EN selects saturating narrowing; otherwise results wrap.
module macc_lane
    import macc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int OUT_WIDTH  = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         adv,
    input  logic                         sqr_in,
    input  logic signed [DATA_WIDTH-1:0] op_0,
    input  logic signed [DATA_WIDTH-1:0] op_1,
    input  logic signed [DATA_WIDTH-1:0] op_add,
    input  logic                         vld_p2,
    input  logic                         acc_p2,
    input  logic                         add_p2,
    input  logic                         last_p2,
    input  logic                         clr_p2,
    input  logic                         vld_p3,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_sat
);

    localparam int RW = ACC_WIDTH - FRAC_BITS;

`ifdef MACC_ARRAY_SAT_EN
    localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] OUT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

    // Round half up: add half an LSB of the result, then drop the fraction
    function automatic logic signed [RW-1:0] round_acc(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] biased;
        biased = a + (ACC_WIDTH'(1) <<< (FRAC_BITS - 1));
        return RW'(biased >>> FRAC_BITS);
    endfunction

    // Narrow to OUT_WIDTH; MSB of the return value is the saturation flag
    function automatic logic [OUT_WIDTH:0] narrow(input logic signed [RW-1:0] r);
`ifdef MACC_ARRAY_SAT_EN
        if (r > OUT_MAX) return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        if (r < OUT_MIN) return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        return {1'b0, r[OUT_WIDTH-1:0]};
`else
        return {1'b0, r[OUT_WIDTH-1:0]};
`endif
    endfunction

    logic signed [DATA_WIDTH-1:0]   a_p1_q, a_p1_d, b_p1_q, b_p1_d, c_p1_q, c_p1_d;
    logic signed [2*DATA_WIDTH-1:0] prod_p2_q, prod_p2_d;
    logic signed [DATA_WIDTH-1:0]   c_p2_q, c_p2_d;
    logic signed [ACC_WIDTH-1:0]    res_p3_q, res_p3_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]    acc_base, addend, sum;
    logic signed [OUT_WIDTH-1:0]    out_q, out_d;
    logic                           sat_q, sat_d;

    // Next-state for all stages; clear zeroes the accumulator before the S3 beat combines
    always_comb begin
        // S1: operand capture, squaring reuses op_0 as multiplier
        a_p1_d = op_0;
        b_p1_d = sqr_in ? op_0 : op_1;
        c_p1_d = op_add;
        // S2: full-precision signed product
        prod_p2_d = a_p1_q * b_p1_q;
        c_p2_d    = c_p1_q;
        // S3: addend select and accumulate
        acc_base = clr_p2 ? '0 : acc_q;
        if (acc_p2)      addend = acc_base;
        else if (add_p2) addend = ACC_WIDTH'(c_p2_q) <<< FRAC_BITS;
        else             addend = '0;
        sum      = ACC_WIDTH'(prod_p2_q) + addend;
        res_p3_d = sum;
        acc_d    = acc_base;
        if (vld_p2 && acc_p2) acc_d = last_p2 ? '0 : sum;
        // S4: round and narrow, load only for an emitted slot
        {sat_d, out_d} = narrow(round_acc(res_p3_q));
        if (!vld_p3) begin
            sat_d = sat_q;
            out_d = out_q;
        end
    end

    // Datapath stage registers, frozen while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (adv) begin
            a_p1_q    <= a_p1_d;
            b_p1_q    <= b_p1_d;
            c_p1_q    <= c_p1_d;
            prod_p2_q <= prod_p2_d;
            c_p2_q    <= c_p2_d;
            res_p3_q  <= res_p3_d;
        end
    end

    // Accumulator and output register, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            out_q <= '0;
            sat_q <= 1'b0;
        end else if (adv) begin
            acc_q <= acc_d;
            out_q <= out_d;
            sat_q <= sat_d;
        end
    end

    assign out_data = out_q;
    assign out_sat  = sat_q;

endmodule

// File: rtl/macc_array.sv
// macc_array: LANES-wide fixed-point multiply-accumulate engine. Owns the
// valid/ready handshake, the valid/last/op/clear pipeline and the emit rule;
// per-lane arithmetic lives in macc_lane.
// MACC_ARRAY_SAT_EN enables saturation of out_data and drives out_sat.
module macc_array
    import macc_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int OUT_WIDTH  = 16,
    parameter int ACC_GUARD  = DEFAULT_ACC_GUARD
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [2:0]                    op_code,
    input  logic [LANES*DATA_WIDTH-1:0]   op_0,
    input  logic [LANES*DATA_WIDTH-1:0]   op_1,
    input  logic [LANES*DATA_WIDTH-1:0]   op_add,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic [LANES-1:0]              out_sat
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ACC_GUARD);

    logic adv;
    logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d, vld_p4_q, vld_p4_d;
    logic clr_p1_q, clr_p1_d, clr_p2_q, clr_p2_d;
    logic acc_p1_q, acc_p1_d, acc_p2_q, acc_p2_d;
    logic add_p1_q, add_p1_d, add_p2_q, add_p2_d;
    logic last_p1_q, last_p1_d, last_p2_q, last_p2_d;

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv && !reset;
    assign out_valid = vld_p4_q;

    // Control pipeline next-state; S3 emits non-accumulate beats and run-final beats
    always_comb begin
        vld_p1_d  = in_valid && in_ready;
        clr_p1_d  = clear;
        acc_p1_d  = op_code[OP_ACC_BIT];
        add_p1_d  = op_code[OP_ADD_BIT];
        last_p1_d = in_last;
        vld_p2_d  = vld_p1_q;
        clr_p2_d  = clr_p1_q;
        acc_p2_d  = acc_p1_q;
        add_p2_d  = add_p1_q;
        last_p2_d = last_p1_q;
        vld_p3_d  = vld_p2_q && (!acc_p2_q || last_p2_q);
        vld_p4_d  = vld_p3_q;
    end

    // Valid and clear pipeline, cleared by reset and frozen on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            vld_p4_q <= 1'b0;
            clr_p1_q <= 1'b0;
            clr_p2_q <= 1'b0;
        end else if (adv) begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            vld_p4_q <= vld_p4_d;
            clr_p1_q <= clr_p1_d;
            clr_p2_q <= clr_p2_d;
        end
    end

    // Op and last qualifiers travel alongside their valid
    always_ff @(posedge clk) begin
        if (adv) begin
            acc_p1_q  <= acc_p1_d;
            add_p1_q  <= add_p1_d;
            last_p1_q <= last_p1_d;
            acc_p2_q  <= acc_p2_d;
            add_p2_q  <= add_p2_d;
            last_p2_q <= last_p2_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        macc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .OUT_WIDTH  (OUT_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .adv      (adv),
            .sqr_in   (op_code[OP_SQR_BIT]),
            .op_0     (op_0[i*DATA_WIDTH +: DATA_WIDTH]),
            .op_1     (op_1[i*DATA_WIDTH +: DATA_WIDTH]),
            .op_add   (op_add[i*DATA_WIDTH +: DATA_WIDTH]),
            .vld_p2   (vld_p2_q),
            .acc_p2   (acc_p2_q),
            .add_p2   (add_p2_q),
            .last_p2  (last_p2_q),
            .clr_p2   (clr_p2_q),
            .vld_p3   (vld_p3_q),
            .out_data (out_data[i*OUT_WIDTH +: OUT_WIDTH]),
            .out_sat  (out_sat[i])
        );
    end

endmodule
